// File: rtl/mantle_arr_tuple_serializer.sv
// Parallel-to-serial converter: captures a 4-element array of {bit, W1-bit} tuples
// and streams the slice [LO, HI) one element per valid/ready handshake.
module mantle_arr_tuple_serializer #(
  parameter int W1      = 2,
  parameter int LO      = 0,
  parameter int HI      = 4,
  parameter int REVERSE = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_0__0,
  input  logic [W1-1:0] in_0__1,
  input  logic          in_1__0,
  input  logic [W1-1:0] in_1__1,
  input  logic          in_2__0,
  input  logic [W1-1:0] in_2__1,
  input  logic          in_3__0,
  input  logic [W1-1:0] in_3__1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out__0,
  output logic [W1-1:0] out__1,
  output logic [1:0]    out_idx,
  output logic          out_last
);

  localparam logic [1:0] START_IDX = (REVERSE != 0) ? 2'(HI - 1) : 2'(LO);
  localparam logic [1:0] LAST_IDX  = (REVERSE != 0) ? 2'(LO) : 2'(HI - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nxt;
  logic [1:0]          cnt, cnt_nxt;
  logic [3:0]          arr_f0;
  logic [3:0][W1-1:0]  arr_f1;
  logic                in_fire, out_fire;

  // Element selection is a pure mux of the held array by the index counter.
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (cnt == LAST_IDX);
  assign out__0    = arr_f0[cnt];
  assign out__1    = arr_f1[cnt];
  assign out_idx   = cnt;
  assign out_fire  = out_valid && out_ready;
  // Combinational from out_ready so the next array loads as the last element retires.
  assign in_ready  = (state == IDLE) || (out_fire && out_last);
  assign in_fire   = in_valid && in_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    if (in_fire) begin
      state_nxt = SEND;
      cnt_nxt   = START_IDX;
    end else if (out_fire) begin
      if (out_last) state_nxt = IDLE;
      else          cnt_nxt   = (REVERSE != 0) ? cnt - 2'd1 : cnt + 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      // NOTE: the array buffer is reset so the muxed outputs read zero out of reset.
      arr_f0 <= '0;
      arr_f1 <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (in_fire) begin
        arr_f0 <= {in_3__0, in_2__0, in_1__0, in_0__0};
        arr_f1 <= {in_3__1, in_2__1, in_1__1, in_0__1};
      end
    end
  end

endmodule

// File: tb/tb_mantle_arr_tuple_serializer.sv
// Self-checking bench: three parameterisations driven in lockstep against a queue-based
// model that expands each accepted array into its expected sequence of output beats.
module tb_mantle_arr_tuple_serializer;

  localparam int NI = 3;

  function automatic int cfg_lo(int g);
    return (g == 0) ? 0 : (g == 1) ? 1 : 2;
  endfunction
  function automatic int cfg_hi(int g);
    return (g == 0) ? 4 : 3;
  endfunction
  function automatic int cfg_rev(int g);
    return (g == 1) ? 1 : 0;
  endfunction

  typedef struct packed {
    logic       f0;
    logic [1:0] f1;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       iv   [NI];
  logic       ir   [NI];
  logic       ov   [NI];
  logic       ordy [NI];
  logic       o0   [NI];
  logic [1:0] o1   [NI];
  logic [1:0] oi   [NI];
  logic       ol   [NI];
  logic [3:0] f0   [NI];
  logic [1:0] f1   [NI][4];

  beat_t q [NI][$];
  logic  ev  [NI];
  logic  eir [NI];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mantle_arr_tuple_serializer #(
      .W1(2), .LO(cfg_lo(g)), .HI(cfg_hi(g)), .REVERSE(cfg_rev(g))
    ) u_dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_0__0   (f0[g][0]),
      .in_0__1   (f1[g][0]),
      .in_1__0   (f0[g][1]),
      .in_1__1   (f1[g][1]),
      .in_2__0   (f0[g][2]),
      .in_2__1   (f1[g][2]),
      .in_3__0   (f0[g][3]),
      .in_3__1   (f1[g][3]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out__0    (o0[g]),
      .out__1    (o1[g]),
      .out_idx   (oi[g]),
      .out_last  (ol[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs are set at the falling edge before calling; checks run 1ns later, then the
  // model advances on the rising edge and the task returns at the next falling edge.
  task automatic step();
    beat_t b;
    #1;
    for (int g = 0; g < NI; g++) begin
      ev[g]  = (q[g].size() != 0);
      b      = ev[g] ? q[g][0] : '0;
      eir[g] = !ev[g] || (ordy[g] && b.last);
      check($sformatf("u%0d out_valid", g), 32'(ov[g]), 32'(ev[g]));
      check($sformatf("u%0d in_ready", g), 32'(ir[g]), 32'(eir[g]));
      if (ev[g]) begin
        check($sformatf("u%0d out__0", g), 32'(o0[g]), 32'(b.f0));
        check($sformatf("u%0d out__1", g), 32'(o1[g]), 32'(b.f1));
        check($sformatf("u%0d out_idx", g), 32'(oi[g]), 32'(b.idx));
        check($sformatf("u%0d out_last", g), 32'(ol[g]), 32'(b.last));
      end else begin
        check($sformatf("u%0d out_last idle", g), 32'(ol[g]), 32'd0);
      end
    end
    @(posedge CLK);
    for (int g = 0; g < NI; g++) begin
      if (RESET) q[g].delete();
      else begin
        if (ev[g] && ordy[g]) void'(q[g].pop_front());
        if (iv[g] && eir[g]) begin
          int n;
          n = cfg_hi(g) - cfg_lo(g);
          for (int k = 0; k < n; k++) begin
            int ix;
            ix = (cfg_rev(g) != 0) ? cfg_hi(g) - 1 - k : cfg_lo(g) + k;
            b.f0   = f0[g][ix];
            b.f1   = f1[g][ix];
            b.idx  = 2'(ix);
            b.last = (k == n - 1);
            q[g].push_back(b);
          end
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic check_reset_values(input string tag);
    #1;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s u%0d out_valid", tag, g), 32'(ov[g]), 32'd0);
      check($sformatf("%s u%0d out_last", tag, g), 32'(ol[g]), 32'd0);
      check($sformatf("%s u%0d out__0", tag, g), 32'(o0[g]), 32'd0);
      check($sformatf("%s u%0d out__1", tag, g), 32'(o1[g]), 32'd0);
      check($sformatf("%s u%0d out_idx", tag, g), 32'(oi[g]), 32'd0);
      check($sformatf("%s u%0d in_ready", tag, g), 32'(ir[g]), 32'd1);
    end
  endtask

  task automatic load_array_a();
    f0[0] = 4'b0101;
    f1[0][0] = 2'd0; f1[0][1] = 2'd1; f1[0][2] = 2'd2; f1[0][3] = 2'd3;
  endtask

  initial begin
    int beats;
    RESET = 1'b1;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; ordy[g] = 1'b1; f0[g] = '0;
      for (int k = 0; k < 4; k++) f1[g][k] = '0;
    end
    @(negedge CLK);
    step();
    step();
    RESET = 1'b0;
    check_reset_values("reset");

    // Default load on u0; slice/reverse on u1; single element on u2.
    load_array_a();
    f0[1] = 4'b0101;
    f1[1][0] = 2'd3; f1[1][1] = 2'd2; f1[1][2] = 2'd1; f1[1][3] = 2'd0;
    f0[2] = 4'b0100;
    f1[2][0] = 2'd1; f1[2][1] = 2'd2; f1[2][2] = 2'd3; f1[2][3] = 2'd0;
    for (int g = 0; g < NI; g++) iv[g] = 1'b1;
    step();
    for (int g = 0; g < NI; g++) iv[g] = 1'b0;
    for (int c = 0; c < 6; c++) step();

    // Backpressure while u0 presents idx 1.
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    ordy[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp held idx", 32'(oi[0]), 32'd1);
    end
    ordy[0] = 1'b1;
    for (int c = 0; c < 4; c++) step();

    // Back-to-back arrays A then B with no bubble.
    iv[0] = 1'b1;
    step();
    f0[0] = 4'b1010;
    f1[0][0] = 2'd3; f1[0][1] = 2'd2; f1[0][2] = 2'd1; f1[0][3] = 2'd0;
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) iv[0] = 1'b0;
      #1 beats += int'(ov[0]);
      step();
    end
    check("b2b beats", 32'(beats), 32'd8);
    step();

    // Reset after idx 1 retires.
    load_array_a();
    iv[0] = 1'b1;
    step();
    iv[0] = 1'b0;
    step();
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_reset_values("midrst");
    for (int c = 0; c < 4; c++) step();

    // Randomised traffic on all instances.
    for (int c = 0; c < 400; c++) begin
      RESET = ($urandom_range(0, 59) == 0);
      for (int g = 0; g < NI; g++) begin
        iv[g]   = ($urandom_range(0, 2) != 0);
        ordy[g] = ($urandom_range(0, 3) != 0);
        f0[g]   = 4'($urandom);
        for (int k = 0; k < 4; k++) f1[g][k] = 2'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
